// File: rtl/video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer
//
// Owns the background and overlay selects feeding the pixel output mux.
// User button pulses are captured into shadow registers and committed only at
// a frame boundary, so every frame is drawn with one consistent mode. An
// optional demo timer advances the background (carrying into the overlay)
// every AUTO_FRAMES frames. A banner flag is raised for BANNER_FRAMES frames
// after each mode change.
//
// Parameters:
//   AUTO_FRAMES   frames between automatic advances (2..65535)
//   BANNER_FRAMES frames banner_out stays high after a change (1..255)
//   SKIP_TARGET3  1: overlay select never takes the reserved value 3
//
// Ports:
//   clk_in         pixel clock
//   rst_n_in       asynchronous active-low reset
//   new_frame_in   single-cycle frame boundary pulse
//   btn_bg_in      single-cycle request for the next background mode
//   btn_target_in  single-cycle request for the next overlay mode
//   auto_en_in     level, enables automatic cycling
//   bg_out         committed background select
//   target_out     committed overlay select
//   pending_out    a manual request awaits the next frame boundary
//   banner_out     mode-changed banner should be drawn
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | shadow selects equal the committed selects
// PENDING | manual press captured, commits at the next frame boundary
// -----------------------------------------------------------------------------
module video_mode_sequencer #(
  parameter int unsigned AUTO_FRAMES   = 120,
  parameter int unsigned BANNER_FRAMES = 60,
  parameter int unsigned SKIP_TARGET3  = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       new_frame_in,
  input  logic       btn_bg_in,
  input  logic       btn_target_in,
  input  logic       auto_en_in,
  output logic [1:0] bg_out,
  output logic [1:0] target_out,
  output logic       pending_out,
  output logic       banner_out
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [15:0] AUTO_LAST  = 16'(AUTO_FRAMES - 1);
  localparam logic [7:0]  BANNER_LD  = 8'(BANNER_FRAMES);

  state_t      state_q, state_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  tg_q, tg_d;
  logic [1:0]  pend_bg_q, pend_bg_d;
  logic [1:0]  pend_tg_q, pend_tg_d;
  logic [15:0] auto_cnt_q, auto_cnt_d;
  logic [7:0]  banner_cnt_q, banner_cnt_d;
  logic        pending_q, pending_d;
  logic        banner_q, banner_d;

  logic        frame_commit;
  logic        auto_due;
  logic [1:0]  base_bg;
  logic [1:0]  base_tg;

  function automatic logic [1:0] next_tg(input logic [1:0] v);
    if ((SKIP_TARGET3 != 0) && (v >= 2'd2)) begin
      return 2'd0;
    end
    return v + 2'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    bg_d         = bg_q;
    tg_d         = tg_q;
    auto_cnt_d   = auto_cnt_q;
    banner_cnt_d = banner_cnt_q;
    base_bg      = pend_bg_q;
    base_tg      = pend_tg_q;

    frame_commit = new_frame_in && (state_q == PENDING);
    auto_due     = new_frame_in && (state_q == IDLE) && auto_en_in &&
                   (auto_cnt_q == AUTO_LAST);

    if (frame_commit) begin
      // Commit the shadow values captured before this cycle; a press in this
      // same cycle lands in the shadow below and waits for the next frame.
      bg_d       = pend_bg_q;
      tg_d       = pend_tg_q;
      auto_cnt_d = 16'd0;
      state_d    = IDLE;
      if ((pend_bg_q != bg_q) || (pend_tg_q != tg_q)) begin
        banner_cnt_d = BANNER_LD;
      end
    end else if (auto_due) begin
      bg_d = bg_q + 2'd1;
      if (bg_q == 2'd3) begin
        tg_d = next_tg(tg_q);
      end
      base_bg      = bg_d;
      base_tg      = tg_d;
      auto_cnt_d   = 16'd0;
      banner_cnt_d = BANNER_LD;
    end else if (new_frame_in) begin
      if ((state_q == IDLE) && auto_en_in) begin
        auto_cnt_d = auto_cnt_q + 16'd1;
      end
      if (banner_cnt_q != 8'd0) begin
        banner_cnt_d = banner_cnt_q - 8'd1;
      end
    end

    if (!auto_en_in) begin
      auto_cnt_d = 16'd0;
    end

    pend_bg_d = btn_bg_in     ? (base_bg + 2'd1)  : base_bg;
    pend_tg_d = btn_target_in ? next_tg(base_tg)  : base_tg;

    if (btn_bg_in || btn_target_in) begin
      state_d = PENDING;
    end

    pending_d = (state_d == PENDING);
    banner_d  = (banner_cnt_d != 8'd0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      bg_q         <= 2'd0;
      tg_q         <= 2'd0;
      pend_bg_q    <= 2'd0;
      pend_tg_q    <= 2'd0;
      auto_cnt_q   <= 16'd0;
      banner_cnt_q <= 8'd0;
      pending_q    <= 1'b0;
      banner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bg_q         <= bg_d;
      tg_q         <= tg_d;
      pend_bg_q    <= pend_bg_d;
      pend_tg_q    <= pend_tg_d;
      auto_cnt_q   <= auto_cnt_d;
      banner_cnt_q <= banner_cnt_d;
      pending_q    <= pending_d;
      banner_q     <= banner_d;
    end
  end

  assign bg_out      = bg_q;
  assign target_out  = tg_q;
  assign pending_out = pending_q;
  assign banner_out  = banner_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_video_mode_sequencer
//
// Directed bench for video_mode_sequencer. Two instances share the stimulus:
// dut0 (AUTO_FRAMES=4, BANNER_FRAMES=60, SKIP_TARGET3=1) and
// dut1 (AUTO_FRAMES=4, BANNER_FRAMES=3,  SKIP_TARGET3=0).
// Expected output words {bg, target, pending, banner} are queued as stimulus
// is applied and popped/compared once the DUT has produced them.
// -----------------------------------------------------------------------------
module tb_video_mode_sequencer;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic new_frame_in;
  logic btn_bg_in;
  logic btn_target_in;
  logic auto_en_in;

  logic [1:0] bg0, tg0, bg1, tg1;
  logic       pend0, ban0, pend1, ban1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    bit         which;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  video_mode_sequencer #(
    .AUTO_FRAMES(4), .BANNER_FRAMES(60), .SKIP_TARGET3(1)
  ) dut0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in),
    .btn_bg_in(btn_bg_in), .btn_target_in(btn_target_in),
    .auto_en_in(auto_en_in), .bg_out(bg0), .target_out(tg0),
    .pending_out(pend0), .banner_out(ban0)
  );

  video_mode_sequencer #(
    .AUTO_FRAMES(4), .BANNER_FRAMES(3), .SKIP_TARGET3(0)
  ) dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in),
    .btn_bg_in(btn_bg_in), .btn_target_in(btn_target_in),
    .auto_en_in(auto_en_in), .bg_out(bg1), .target_out(tg1),
    .pending_out(pend1), .banner_out(ban1)
  );

  function automatic logic [5:0] pk(input int bg, input int tg,
                                    input bit p, input bit b);
    return {2'(bg), 2'(tg), p, b};
  endfunction

  task automatic expect_out(input string tag, input bit which,
                            input logic [5:0] exp);
    exp_t e;
    e.tag = tag; e.which = which; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [5:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.which ? {bg1, tg1, pend1, ban1} : {bg0, tg0, pend0, ban0};
      n_checks++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic press_bg();
    btn_bg_in = 1'b1;
    tick();
    btn_bg_in = 1'b0;
  endtask

  task automatic press_tg();
    btn_target_in = 1'b1;
    tick();
    btn_target_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0; new_frame_in = 1'b0; btn_bg_in = 1'b0;
    btn_target_in = 1'b0; auto_en_in = 1'b0;

    // Reset, then idle frames
    tick();
    expect_out("reset_dut0", 0, pk(0, 0, 0, 0));
    expect_out("reset_dut1", 1, pk(0, 0, 0, 0));
    check_all();
    rst_n_in = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      expect_out($sformatf("idle_frame%0d", i), 0, pk(0, 0, 0, 0));
      check_all();
      tick();
    end

    // Accumulated presses and 60-frame banner
    press_bg();
    expect_out("acc_pending", 0, pk(0, 0, 1, 0));
    check_all();
    tick();
    press_bg();
    press_bg();
    expect_out("acc_pending3", 0, pk(0, 0, 1, 0));
    check_all();
    frame_pulse();
    expect_out("acc_commit", 0, pk(3, 0, 0, 1));
    check_all();
    for (int i = 1; i <= 60; i++) begin
      tick();
      frame_pulse();
      expect_out($sformatf("banner_f%0d", i), 0, pk(3, 0, 0, (i < 60)));
      check_all();
    end

    // Overlay sequence with and without skip of value 3
    do_reset();
    begin
      int exp0 [4] = '{1, 2, 0, 1};
      int exp1 [4] = '{1, 2, 3, 0};
      for (int i = 0; i < 4; i++) begin
        press_tg();
        tick();
        frame_pulse();
        expect_out($sformatf("skip1_p%0d", i), 0, pk(0, exp0[i], 0, 1));
        expect_out($sformatf("skip0_p%0d", i), 1, pk(0, exp1[i], 0, 1));
        check_all();
        tick();
      end
    end

    // Automatic cycling with carry into the overlay
    do_reset();
    auto_en_in = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      frame_pulse();
      expect_out($sformatf("auto_f%0d", k), 0,
                 pk((k / 4) % 4, (k >= 16) ? 1 : 0, 0, (k >= 4)));
      check_all();
      tick();
    end
    auto_en_in = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      frame_pulse();
      tick();
    end
    expect_out("auto_off_hold", 0, pk(0, 1, 0, 1));
    check_all();

    // Press coincident with the frame pulse from IDLE
    do_reset();
    btn_bg_in = 1'b1;
    frame_pulse();
    btn_bg_in = 1'b0;
    expect_out("coinc_nochange", 0, pk(0, 0, 1, 0));
    check_all();
    tick();
    frame_pulse();
    expect_out("coinc_commit", 0, pk(1, 0, 0, 1));
    check_all();

    // Manual commit on an auto-due frame takes priority
    do_reset();
    auto_en_in = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      frame_pulse();
      tick();
    end
    press_bg();
    press_bg();
    expect_out("prio_pending", 0, pk(0, 0, 1, 0));
    check_all();
    frame_pulse();
    expect_out("prio_manual", 0, pk(2, 0, 0, 1));
    check_all();
    for (int k = 1; k <= 4; k++) begin
      tick();
      frame_pulse();
      expect_out($sformatf("prio_after_f%0d", k), 0,
                 pk((k == 4) ? 3 : 2, 0, 0, 1));
      check_all();
    end

    // Reset asserted while PENDING with banner high
    tick();
    press_bg();
    expect_out("midrst_pending", 0, pk(3, 0, 1, 1));
    check_all();
    #2;
    rst_n_in = 1'b0;
    #1;
    expect_out("midrst_dut0", 0, pk(0, 0, 0, 0));
    expect_out("midrst_dut1", 1, pk(0, 0, 0, 0));
    check_all();
    auto_en_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    frame_pulse();
    expect_out("midrst_nocommit", 0, pk(0, 0, 0, 0));
    check_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_mode_sequencer.md
# video_mode_sequencer

Frame-synchronous controller for the pixel output mux: it owns the 2-bit background select and the 2-bit overlay select that drive the mux, and cycles them from user button pulses or an automatic demo timer. Selection changes are committed only at frame boundaries, so no frame is ever drawn with mixed modes. It also drives a "mode changed" banner flag for a fixed number of frames after each commit. It sits between the button conditioning logic and the mux select inputs, in the pixel clock domain.

## Interface
- `AUTO_FRAMES`, default 120: number of frames between automatic advances; legal range 2 to 65535.
- `BANNER_FRAMES`, default 60: number of frames `banner_out` stays high after a commit; legal range 1 to 255.
- `SKIP_TARGET3`, default 1: when 1, the overlay select never takes the reserved value 3.

Ports:
- `clk_in` input 1: pixel clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `new_frame_in` input 1: single-cycle pulse at the frame boundary.
- `btn_bg_in` input 1: single-cycle pulse, already debounced; requests the next background mode.
- `btn_target_in` input 1: single-cycle pulse, already debounced; requests the next overlay mode.
- `auto_en_in` input 1: level input that enables automatic cycling.
- `bg_out` output 2: committed background select for the mux.
- `target_out` output 2: committed overlay select for the mux.
- `pending_out` output 1: a manual request is waiting for the next frame boundary.
- `banner_out` output 1: asserted while the mode-changed banner should be drawn.

## Operation
- **Registers:** committed `bg_out` and `target_out`; shadow `pend_bg` and `pend_tg`; 16-bit auto frame counter `auto_cnt`; 8-bit `banner_cnt`.
- **States:**
  - IDLE: shadow registers equal the committed values.
  - PENDING: a manual press has been captured but not yet committed.
- **Manual press:**
  - `btn_bg_in` sets `pend_bg` to `pend_bg+1` mod 4.
  - `btn_target_in` sets `pend_tg` to the next overlay value.
  - Next overlay value: 0→1→2→3→0. When `SKIP_TARGET3`=1 the sequence is 0→1→2→0.
  - Any press moves the FSM to PENDING.
  - Multiple presses within one frame accumulate: each press advances the shadow value once more.
  - Both buttons pressed in the same cycle advance both shadow values.
- **Commit:**
  - Triggered by `new_frame_in` while in PENDING.
  - `bg_out`/`target_out` load `pend_bg`/`pend_tg`, the FSM returns to IDLE, and `auto_cnt` is cleared.
  - If the committed value differs from the previous one, `banner_cnt` loads `BANNER_FRAMES`. If presses wrapped back to the same value, `banner_cnt` is not loaded.
- **Auto mode** (applies only in IDLE with `auto_en_in`=1):
  - Each `new_frame_in` increments `auto_cnt`.
  - On the `new_frame_in` where `auto_cnt`==`AUTO_FRAMES`-1:
    - `auto_cnt` returns to 0.
    - `bg_out` advances mod 4.
    - If `bg_out` was 3, `target_out` also advances per the overlay rule.
    - Shadow registers track the new values.
    - `banner_cnt` loads `BANNER_FRAMES`.
  - When `auto_en_in`=0, `auto_cnt` is held at 0.
- **Priority:** a manual commit always takes priority over an auto advance in the same frame. Only the manual commit is applied, and `auto_cnt` is cleared.
- **Banner:**
  - Each `new_frame_in` with no commit or advance decrements a nonzero `banner_cnt`.
  - `banner_out` = (`banner_cnt` != 0).
  - A new commit reloads `banner_cnt`, restarting the banner.
- **Auto-enable edges:** `auto_en_in` falling mid-count zeroes `auto_cnt` on the next cycle. It never alters the committed selects.

## Timing
- **Reset values:** all outputs are 0 (`bg_out`=0, `target_out`=0, `pending_out`=0, `banner_out`=0). `auto_cnt`=0, `banner_cnt`=0, shadow registers are 0, FSM is IDLE.
- Reset takes effect immediately on assertion, at any point including mid-PENDING. Release is synchronous to `clk_in`.
- **Button latency:** a press in cycle N raises `pending_out` in N+1.
- **Commit latency:** with `new_frame_in` high in cycle F, the committed selects, `pending_out`=0 and `banner_out`=1 all appear in F+1.
- **Press coincident with `new_frame_in` (cycle F):**
  - The press is not included in this commit. It updates the shadow registers.
  - If the FSM was in PENDING, the earlier shadow values commit and the FSM stays in PENDING for the next frame.
  - If the FSM was in IDLE, it enters PENDING with no commit this frame.
- **Auto advance:** outputs change in the cycle after the qualifying `new_frame_in`.
- **Banner duration:** `banner_out` falls in the cycle after the `BANNER_FRAMES`-th `new_frame_in` following the commit.
- **Glitch-free:** all outputs are registered. `bg_out` and `target_out` change only in the cycle following a `new_frame_in`.

## Test plan
- **Reset then idle:** release reset, run 3 frames with no stimulus → `bg_out`=0, `target_out`=0, `pending_out`=0, `banner_out`=0 throughout.
- **Accumulated press:** 3 `btn_bg_in` pulses mid-frame, then `new_frame_in` → `pending_out`=1 after the first pulse; `bg_out`=3 one cycle after the frame pulse; `banner_out` stays high for exactly 60 frames.
- **Overlay skip:** `SKIP_TARGET3`=1, 3 `btn_target_in` pulses in separate frames → `target_out` goes 1, 2, 0 and never shows 3. With `SKIP_TARGET3`=0, 4 pulses → 1, 2, 3, 0.
- **Auto carry:** `AUTO_FRAMES`=4, `auto_en_in`=1, 16 frames → `bg_out` goes 1, 2, 3, 0. On the 4th advance `target_out` goes 0→1. Advances land every 4th frame.
- **Simultaneous events:** a `btn_bg_in` coincident with `new_frame_in` from IDLE → no change that frame; `bg_out`=1 after the next frame. A manual commit on an auto-due frame → only the manual value is applied, and the next auto advance comes 4 frames later.
- **Reset mid-operation:** assert `rst_n_in` while in PENDING with `banner_out`=1 → all outputs are 0 immediately, and the following frame boundary commits nothing.
